// File: rtl/muldiv_pkg.sv
// Shared constants and types for the M-extension multiply/divide unit.
// No logic: funct3/funct7 codes, FSM state encoding, decoded-op struct.
// Imported by the decoder and by the top-level unit.
package muldiv_pkg;

  // M-extension funct3 operation codes
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // funct7 value that steers an OP/OP-32 instruction to this unit
  localparam logic [6:0] MEXT_FUNCT7 = 7'b0000001;

  // Control FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Decoded operation attributes
  typedef struct packed {
    logic is_div;
    logic a_signed;
    logic b_signed;
    logic want_high;
    logic want_rem;
  } mdu_dec_t;

endpackage

// File: rtl/mdu_op_decode.sv
// Decodes M-extension funct3 into datapath control flags.
// Purely combinational, zero latency.
// No handshake; output follows input.
module mdu_op_decode
  import muldiv_pkg::*;
(
  input  logic [2:0] funct3,
  output logic       is_div,
  output logic       a_signed,
  output logic       b_signed,
  output logic       want_high,
  output logic       want_rem
);

  // Operand signedness and result selection per operation
  always_comb begin
    is_div    = funct3[2];
    a_signed  = 1'b0;
    b_signed  = 1'b0;
    want_high = 1'b0;
    want_rem  = 1'b0;
    case (funct3)
      F3_MUL: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      F3_MULH: begin
        a_signed  = 1'b1;
        b_signed  = 1'b1;
        want_high = 1'b1;
      end
      F3_MULHSU: begin
        a_signed  = 1'b1;
        want_high = 1'b1;
      end
      F3_MULHU: begin
        want_high = 1'b1;
      end
      F3_DIV: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      F3_DIVU: begin
      end
      F3_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
        want_rem = 1'b1;
      end
      F3_REMU: begin
        want_rem = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide: radix-2 shift-add multiply, restoring divide.
// Latency XLEN+2 cycles from accepted start to done; div-by-zero/overflow finish in 1.
// start only sampled in IDLE/DONE (no queueing); kill aborts to IDLE without done.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int               CNT_W    = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  logic [1:0]        state_q, state_d;
  mdu_dec_t          dec_q, dec_d, dec_in;
  logic              sign_a_q, sign_a_d;   // raw operand MSBs; signedness applied at FIX
  logic              sign_b_q, sign_b_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic in_is_div, in_a_signed, in_b_signed, in_want_high, in_want_rem;

  mdu_op_decode u_dec (
    .funct3    (funct3),
    .is_div    (in_is_div),
    .a_signed  (in_a_signed),
    .b_signed  (in_b_signed),
    .want_high (in_want_high),
    .want_rem  (in_want_rem)
  );

  assign dec_in = {in_is_div, in_a_signed, in_b_signed, in_want_high, in_want_rem};

  // Accept-time operand magnitudes and special-case detection
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_by_zero, div_ovf;

  assign mag_a       = (dec_in.a_signed && src_a[XLEN-1]) ? -src_a : src_a;
  assign mag_b       = (dec_in.b_signed && src_b[XLEN-1]) ? -src_b : src_b;
  assign div_by_zero = dec_in.is_div && (src_b == '0);
  assign div_ovf     = dec_in.is_div && dec_in.a_signed &&
                       (src_a == MOST_NEG) && (src_b == ALL_ONES);

  // One iteration of each algorithm; both run every CALC cycle, FIX picks one
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_step;
  logic [XLEN:0]     rem_sh, div_diff;

  assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? mcand_q : '0)};
  assign prod_step = {mul_sum, prod_q[XLEN-1:1]};
  assign rem_sh    = {rem_q, quot_q[XLEN-1]};
  assign div_diff  = rem_sh - {1'b0, divisor_q};

  // Sign correction and result selection
  logic              neg_a, neg_b;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  assign neg_a    = dec_q.a_signed & sign_a_q;
  assign neg_b    = dec_q.b_signed & sign_b_q;
  assign prod_fix = (neg_a ^ neg_b) ? -prod_q : prod_q;
  assign quot_fix = (neg_a ^ neg_b) ? -quot_q : quot_q;
  assign rem_fix  = neg_a ? -rem_q : rem_q;
  assign fix_res  = dec_q.is_div ? (dec_q.want_rem ? rem_fix : quot_fix)
                                 : (dec_q.want_high ? prod_fix[2*XLEN-1:XLEN]
                                                    : prod_fix[XLEN-1:0]);

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    dec_d     = dec_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    mcand_d   = mcand_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    result_d  = result_q;

    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            dec_d     = dec_in;
            sign_a_d  = src_a[XLEN-1];
            sign_b_d  = src_b[XLEN-1];
            mcand_d   = mag_a;
            divisor_d = mag_b;
            quot_d    = mag_a;
            rem_d     = '0;
            prod_d    = {{XLEN{1'b0}}, mag_b};
            cnt_d     = CNT_LOAD;
            if (div_by_zero) begin
              result_d = dec_in.want_rem ? src_a : ALL_ONES;
              state_d  = ST_DONE;
            end else if (div_ovf) begin
              result_d = dec_in.want_rem ? '0 : src_a;
              state_d  = ST_DONE;
            end else begin
              state_d = ST_CALC;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CALC: begin
          prod_d = prod_step;
          if (!div_diff[XLEN]) begin
            rem_d  = div_diff[XLEN-1:0];
            quot_d = {quot_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d  = rem_sh[XLEN-1:0];
            quot_d = {quot_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          result_d = fix_res;
          state_d  = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers, async active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dec_q     <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      mcand_q   <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      dec_q     <= dec_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      mcand_q   <= mcand_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32.
// Cycle 0 is the cycle in which start is high; outputs sampled on the falling edge.
// Inputs are driven 1ns after the rising edge.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .src_a  (src_a),
    .src_b  (src_b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one op (start high in the current cycle), scramble inputs after accept,
  // optionally pulse a stray start at poke_cyc, then wait for done and check.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat,
                        input int poke_cyc);
    int cyc;
    int busy_cnt;
    bit seen;
    funct3 = f3;
    src_a  = a;
    src_b  = b;
    start  = 1'b1;
    next_cycle();
    start    = 1'b0;
    funct3   = 3'b011;
    src_a    = $urandom;
    src_b    = $urandom;
    cyc      = 1;
    busy_cnt = 0;
    seen     = 1'b0;
    while (cyc < 200 && !seen) begin
      if (cyc == poke_cyc) start = 1'b1;
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        next_cycle();
        start = 1'b0;
        cyc++;
      end
    end
    check({tag, "_done"}, 64'(seen), 64'd1);
    check({tag, "_res"}, 64'(result), 64'(exp_res));
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_busy"}, 64'(busy_cnt), 64'(exp_lat - 1));
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    funct3 = 3'b000;
    src_a  = '0;
    src_b  = '0;
    kill   = 1'b0;

    // Reset values before any clock edge
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // Basic multiply with exact latency, then done must drop
    run_op("mul_7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 0);
    next_cycle();
    @(negedge clk);
    check("mul_done_pulse", 64'(done), 64'd0);
    next_cycle();

    // High-half multiplies
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0);
    next_cycle();
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0);
    next_cycle();
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0);
    next_cycle();

    // Special cases finish in cycle 1
    run_op("div_by0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    next_cycle();
    run_op("remu_by0", 3'b111, 32'd5, 32'd0, 32'd5, 1, 0);
    next_cycle();
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    next_cycle();
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    next_cycle();

    // Regular divides
    run_op("div_-7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
    next_cycle();
    run_op("rem_-7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
    next_cycle();
    run_op("divu_100/7", 3'b101, 32'd100, 32'd7, 32'd14, 34, 0);
    next_cycle();
    run_op("remu_100/7", 3'b111, 32'd100, 32'd7, 32'd2, 34, 0);
    next_cycle();

    // Kill in cycle 10 of a multiply; result must keep the previous value (2)
    funct3 = 3'b000;
    src_a  = 32'd3;
    src_b  = 32'd5;
    start  = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (9) next_cycle();
    kill = 1'b1;
    next_cycle();
    kill = 1'b0;
    @(negedge clk);
    check("kill_busy", 64'(busy), 64'd0);
    check("kill_done", 64'(done), 64'd0);
    check("kill_result", 64'(result), 64'd2);
    next_cycle();
    run_op("after_kill", 3'b000, 32'd3, 32'd5, 32'd15, 34, 0);
    next_cycle();

    // Stray start in cycle 5 of a busy divide is ignored
    run_op("div_poke", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 5);
    next_cycle();

    // Back-to-back: second start issued in the DONE cycle of the first
    run_op("b2b_first", 3'b011, 32'h0001_0000, 32'h0001_0000, 32'd1, 34, 0);
    run_op("b2b_second", 3'b101, 32'd1000, 32'd10, 32'd100, 34, 0);
    next_cycle();

    // Async reset mid-CALC clears outputs before the next clock edge
    funct3 = 3'b000;
    src_a  = 32'd9;
    src_b  = 32'd9;
    start  = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (5) next_cycle();
    check("pre_rst_busy", 64'(busy), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    check("async_rst_result", 64'(result), 64'd0);
    next_cycle();
    reset = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) check("post_rst_no_done", 64'(done), 64'd0);
      next_cycle();
    end
    check("post_rst_result", 64'(result), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative, parametrised RV32M/RV64M multiply-divide execute unit for the multi-cycle CPU datapath.
- Decodes M-extension funct3 into eight operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Computes results with a radix-2 shift-add multiplier and a restoring divider, one bit per cycle.
- Uses a start/busy/done handshake so the control FSM can stall the pipeline.
- Sits beside the main ALU; its result is muxed onto the writeback path.

Parameters:
- XLEN, 32, operand/result width; any even value ≥ 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when state is IDLE or DONE
- funct3  in  3  M-extension operation select
- src_a  in  XLEN  rs1 operand (multiplicand / dividend)
- src_b  in  XLEN  rs2 operand (multiplier / divisor)
- kill  in  1  abort current operation (branch flush)
- busy  out  1  high while in CALC or FIX
- done  out  1  one-cycle pulse; result valid
- result  out  XLEN  registered result; held until the next accepted start

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, result=0, all internal registers 0.
- States:
  - IDLE: start → CALC, or → DONE on a special case.
  - CALC: runs XLEN cycles, then → FIX.
  - FIX: 1 cycle, → DONE.
  - DONE: done=1 for exactly 1 cycle, then → IDLE. A start in DONE is accepted (back-to-back) with the same transitions as from IDLE.
- Operation decode from funct3:
  - 000 MUL: low XLEN bits.
  - 001 MULH: signed×signed, high XLEN bits.
  - 010 MULHSU: signed a × unsigned b, high bits.
  - 011 MULHU: unsigned×unsigned, high bits.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- On accept: latch funct3, the magnitudes of both operands (per their signedness), and the sign flags.
  - Product register: 2·XLEN bits.
  - Divider: XLEN-bit remainder and quotient.
  - Counter loaded with XLEN.
- CALC:
  - Multiply: if multiplier LSB=1, add the multiplicand into the upper half; shift right one bit per cycle.
  - Divide: shift {rem,quot} left; trial-subtract the divisor; keep the difference and set the quotient bit if non-negative.
  - Counter decrements each cycle; leave CALC when it reaches 1.
- FIX (sign correction):
  - Product is negated if sign_a^sign_b, applying operand signedness only.
  - Quotient is negated if sign_a^sign_b.
  - Remainder takes the sign of the dividend.
  - Select low/high half or quotient/remainder and register into result.
- Latency: with start high in cycle 0, done=1 in cycle XLEN+2 (cycle 34 at XLEN=32).
- Special cases (IDLE/DONE → DONE directly; done in cycle 1; result written on the accept edge):
  - Divide by zero: DIV/DIVU → all-ones; REM/REMU → src_a.
  - Signed overflow (src_a = most-negative, src_b = −1): DIV → src_a; REM → 0.
- kill:
  - From any state, next state is IDLE; done is not asserted; result is unchanged.
  - kill and start in the same cycle: kill wins, start is ignored.
- start in CALC or FIX is ignored; no queueing.
- funct3 and operand changes after accept have no effect.
- Reset mid-operation: immediate return to reset values; no done.

Decomposition:
- Shared package muldiv_pkg:
  - localparams for the eight funct3 codes;
  - state encoding: IDLE, CALC, FIX, DONE;
  - M-extension funct7 constant 7'b0000001 for the main decoder.
- One natural combinational sub-module, mdu_op_decode: funct3 → is_div, a_signed, b_signed, want_high, want_rem.

Test Plan (XLEN=32):
1. MUL src_a=7, src_b=0xFFFFFFFD (−3), start in cycle 0 → busy=1 in cycles 1–33, done=1 only in cycle 34, result=0xFFFFFFEB.
2. MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
3. DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
4. DIV 5/0 → 0xFFFFFFFF, and REMU 5/0 → 5, each with done in cycle 1; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
5. MUL started in cycle 0, kill in cycle 10 → busy=0 from cycle 11, done never pulses, result unchanged; a new start in cycle 12 completes normally in cycle 46.
6. start pulsed in cycle 5 of a busy DIV → ignored, original result intact. Async reset asserted mid-CALC → busy=done=result=0 immediately, before the next clock edge. Back-to-back start in the DONE cycle → second op accepted.
